// File: rtl/id_stage_pipe_if.sv
// IF->ID fetch channel and ID->EX decoded-bundle channel, both valid/ready.
interface id_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imme;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [3:0]      out_alu_op;
  logic            out_md_en;
  logic [2:0]      out_md_op;
  logic [11:0]     out_ctrl;
  logic            out_illegal;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_imme, out_rs1, out_rs2, out_rd,
           out_funct3, out_alu_op, out_md_en, out_md_op, out_ctrl, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_imme, out_rs1, out_rs2, out_rd,
           out_funct3, out_alu_op, out_md_en, out_md_op, out_ctrl, out_illegal
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Registered RV32 decode stage, 1-cycle latency from accept to out_*.
// in_ready drops on a load-use hazard or while EX leaves the held bundle unconsumed.
module id_stage_pipe #(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  id_stage_pipe_if.slave   bus,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef struct packed {
    logic       jal;
    logic       jalr;
    logic       branch;
    logic       lui;
    logic       auipc;
    logic       reg_wen;
    logic       mem_wen;
    logic       mem_ren;
    logic       alu_b_src;
    logic [1:0] reg_src;
    logic       ebreak;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imme;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic            md_en;
    logic [2:0]      md_op;
    ctrl_t           ctrl;
    logic            illegal;
  } bundle_t;

  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_sel = ALU_SLL;
      3'b010:  alu_sel = ALU_SLT;
      3'b011:  alu_sel = ALU_SLTU;
      3'b100:  alu_sel = ALU_XOR;
      3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

  logic [31:0]      instr;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             illegal;
  logic             rs2_used;
  logic             hazard;
  logic             xfer;
  bundle_t          dec;
  bundle_t          bundle_d, bundle_q;
  logic             out_valid_d, out_valid_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    illegal    = 1'b0;
    dec        = '0;
    dec.pc     = bus.in_pc;
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.rd     = instr[11:7];
    dec.funct3 = funct3;
    dec.alu_op = ALU_ADD;
    case (opcode)
      OP_R: begin
        dec.ctrl.alu_b_src = 1'b1;
        dec.alu_op         = alu_sel(funct3, funct7[5]);
        if (funct7 == 7'b0000001) begin
          illegal   = ~M_EXT;
          dec.md_en = M_EXT;
          dec.md_op = M_EXT ? funct3 : 3'd0;
          if (M_EXT) dec.alu_op = ALU_ADD;
        end else begin
          illegal = !((funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
        end
      end
      OP_IMM: begin
        dec.imme   = XLEN'($signed(instr[31:20]));
        dec.alu_op = alu_sel(funct3, funct7[5] & (funct3 == 3'b101));
        // Shift-immediate funct7 must be a real shift encoding
        illegal    = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                     ((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000));
      end
      OP_LOAD: begin
        dec.imme         = XLEN'($signed(instr[31:20]));
        dec.ctrl.reg_src = 2'b01;
      end
      OP_STORE: dec.imme = XLEN'($signed({instr[31:25], instr[11:7]}));
      OP_BRANCH: begin
        dec.imme           = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        dec.ctrl.branch    = 1'b1;
        dec.ctrl.alu_b_src = 1'b1;
        dec.alu_op         = funct3[1] ? ALU_SLTU : ALU_SLT;
        illegal            = (funct3[2:1] == 2'b01);
      end
      OP_JAL: begin
        dec.imme         = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        dec.ctrl.jal     = 1'b1;
        dec.ctrl.reg_src = 2'b10;
      end
      OP_JALR: begin
        dec.imme         = XLEN'($signed(instr[31:20]));
        dec.ctrl.jalr    = 1'b1;
        dec.ctrl.reg_src = 2'b10;
      end
      OP_LUI: begin
        dec.imme         = XLEN'($signed({instr[31:12], 12'h000}));
        dec.ctrl.lui     = 1'b1;
        dec.ctrl.reg_src = 2'b11;
      end
      OP_AUIPC: begin
        dec.imme       = XLEN'($signed({instr[31:12], 12'h000}));
        dec.ctrl.auipc = 1'b1;
      end
      OP_SYSTEM: dec.imme = XLEN'($signed(instr[31:20]));
      default:   illegal  = 1'b1;
    endcase
    dec.ctrl.ebreak  = (instr == 32'h0010_0073);
    dec.ctrl.reg_wen = !((opcode == OP_STORE) || (opcode == OP_BRANCH) ||
                         (opcode == 7'd0) || illegal);
    dec.ctrl.mem_wen = (opcode == OP_STORE) & ~illegal;
    dec.ctrl.mem_ren = (opcode == OP_LOAD) & ~illegal;
    // Illegal bundles still travel to EX so it can raise the trap, but must not act
    if (illegal) begin
      dec.ctrl.jal    = 1'b0;
      dec.ctrl.jalr   = 1'b0;
      dec.ctrl.branch = 1'b0;
    end
    dec.illegal = illegal;
  end

  assign rs2_used = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign hazard   = bus.in_valid & out_valid_q & bundle_q.ctrl.mem_ren & (bundle_q.rd != 5'd0) &
                    ((instr[19:15] == bundle_q.rd) | (rs2_used & (instr[24:20] == bundle_q.rd)));
  assign bus.in_ready = ~hazard & (~out_valid_q | bus.out_ready);
  assign xfer         = bus.in_valid & bus.in_ready & ~flush;

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = bundle_q.pc;
  assign bus.out_imme    = bundle_q.imme;
  assign bus.out_rs1     = bundle_q.rs1;
  assign bus.out_rs2     = bundle_q.rs2;
  assign bus.out_rd      = bundle_q.rd;
  assign bus.out_funct3  = bundle_q.funct3;
  assign bus.out_alu_op  = bundle_q.alu_op;
  assign bus.out_md_en   = bundle_q.md_en;
  assign bus.out_md_op   = bundle_q.md_op;
  assign bus.out_ctrl    = bundle_q.ctrl;
  assign bus.out_illegal = bundle_q.illegal;
  assign stall_cnt       = stall_cnt_q;
endmodule
